// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode of the fetched word, registered into a
// two-deep (main + skid) pipeline slot with valid/ready handshakes on both sides.
module decode_stage #(
  parameter int XLEN          = 32,
  parameter bit ENABLE_M      = 1'b0,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [2:0]      func3,
  output logic [31:0]     imm,
  output logic [4:0]      alu_ctrl,
  output logic            alu_src1_is_pc,
  output logic            alu_src2_is_imm,
  output logic            use_mem,
  output logic            mem_write,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_jalr,
  output logic            do_write_back,
  output logic            is_muldiv,
  output logic            is_system,
  output logic            illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // NOP shares the all-zero encoding with ADD; the flags tell execute what to do.
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_NOP = 5'b00000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      func3;
    logic [31:0]     imm;
    logic [4:0]      alu_ctrl;
    logic            alu_src1_is_pc;
    logic            alu_src2_is_imm;
    logic            use_mem;
    logic            mem_write;
    logic            is_branch;
    logic            is_jump;
    logic            is_jalr;
    logic            do_write_back;
    logic            is_muldiv;
    logic            is_system;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } state_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  bundle_t dec;
  logic    fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
  logic    legal;

  always_comb begin
    dec   = '0;
    fmt_r = 1'b0;
    fmt_i = 1'b0;
    fmt_s = 1'b0;
    fmt_b = 1'b0;
    fmt_u = 1'b0;
    fmt_j = 1'b0;
    legal = 1'b1;

    case (opcode)
      OPC_LUI: begin
        fmt_u               = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        dec.alu_ctrl        = ALU_ADD;
      end
      OPC_AUIPC: begin
        fmt_u               = 1'b1;
        dec.alu_src1_is_pc  = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        dec.alu_ctrl        = ALU_ADD;
      end
      OPC_JAL: begin
        fmt_j               = 1'b1;
        dec.alu_src1_is_pc  = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        dec.is_jump         = 1'b1;
        dec.alu_ctrl        = ALU_NOP;
      end
      OPC_JALR: begin
        fmt_i               = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        dec.is_jump         = 1'b1;
        dec.is_jalr         = 1'b1;
        dec.alu_ctrl        = ALU_NOP;
        legal               = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        fmt_b         = 1'b1;
        dec.is_branch = 1'b1;
        dec.alu_ctrl  = {2'b10, f3};
        legal         = (f3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        fmt_i               = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        dec.use_mem         = 1'b1;
        dec.alu_ctrl        = ALU_ADD;
        legal               = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
      end
      OPC_STORE: begin
        fmt_s               = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        dec.use_mem         = 1'b1;
        dec.mem_write       = 1'b1;
        dec.alu_ctrl        = ALU_ADD;
        legal               = (f3 < 3'b011);
      end
      OPC_OP_IMM: begin
        fmt_i               = 1'b1;
        dec.alu_src2_is_imm = 1'b1;
        // Only SRAI borrows bit 30 as the arithmetic selector; ADDI etc. keep it as immediate.
        dec.alu_ctrl        = {1'b0, (f3 == 3'b101) && in_instr[30], f3};
        if (f3 == 3'b001) begin
          legal = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end
      end
      OPC_OP: begin
        fmt_r = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_ctrl = {2'b00, f3};
        end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          dec.alu_ctrl = {2'b01, f3};
        end else if ((f7 == 7'b0000001) && ENABLE_M) begin
          dec.is_muldiv = 1'b1;
          dec.alu_ctrl  = {2'b00, f3};
        end else begin
          legal = 1'b0;
        end
      end
      OPC_MISC_MEM: begin
        dec.alu_ctrl = ALU_NOP;
      end
      OPC_SYSTEM: begin
        fmt_i         = 1'b1;
        dec.is_system = 1'b1;
        legal         = ENABLE_SYSTEM &&
                        ((in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073));
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    dec.pc       = in_pc;
    dec.rs1_addr = (fmt_r || fmt_i || fmt_s || fmt_b) ? in_instr[19:15] : 5'd0;
    dec.rs2_addr = (fmt_r || fmt_s || fmt_b) ? in_instr[24:20] : 5'd0;
    dec.rd_addr  = (fmt_r || fmt_i || fmt_u || fmt_j) ? in_instr[11:7] : 5'd0;
    dec.func3    = (fmt_r || fmt_i || fmt_s || fmt_b) ? f3 : 3'd0;

    if (fmt_i) begin
      dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
    end else if (fmt_s) begin
      dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    end else if (fmt_b) begin
      dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
    end else if (fmt_u) begin
      dec.imm = {in_instr[31:12], 12'd0};
    end else if (fmt_j) begin
      dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
    end

    dec.do_write_back = (fmt_r || fmt_i || fmt_u || fmt_j) && (dec.rd_addr != 5'd0);

    // Illegal words still travel down the pipe, but must not cause any side effect.
    if (!legal) begin
      dec.use_mem       = 1'b0;
      dec.mem_write     = 1'b0;
      dec.is_branch     = 1'b0;
      dec.is_jump       = 1'b0;
      dec.is_jalr       = 1'b0;
      dec.do_write_back = 1'b0;
      dec.is_muldiv     = 1'b0;
      dec.is_system     = 1'b0;
      dec.alu_ctrl      = ALU_NOP;
      dec.illegal       = 1'b1;
    end
  end

  state_t  state_q, state_d;
  bundle_t main_q, skid_q;
  logic    accept;
  logic    load_main_dec, load_main_skid, load_skid;

  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d        = state_q;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_dec = 1'b1;
            state_d       = FULL;
          end
        end
        FULL: begin
          if (accept && out_ready) begin
            load_main_dec = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = SKID;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_d        = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_dec) begin
        main_q <= dec;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign out_pc          = main_q.pc;
  assign rs1_addr        = main_q.rs1_addr;
  assign rs2_addr        = main_q.rs2_addr;
  assign rd_addr         = main_q.rd_addr;
  assign func3           = main_q.func3;
  assign imm             = main_q.imm;
  assign alu_ctrl        = main_q.alu_ctrl;
  assign alu_src1_is_pc  = main_q.alu_src1_is_pc;
  assign alu_src2_is_imm = main_q.alu_src2_is_imm;
  assign use_mem         = main_q.use_mem;
  assign mem_write       = main_q.mem_write;
  assign is_branch       = main_q.is_branch;
  assign is_jump         = main_q.is_jump;
  assign is_jalr         = main_q.is_jalr;
  assign do_write_back   = main_q.do_write_back;
  assign is_muldiv       = main_q.is_muldiv;
  assign is_system       = main_q.is_system;
  assign illegal         = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two parameterisations driven in lockstep, checked against a
// FIFO-of-raw-words pipeline model plus a table-style RV32 decode reference.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        src1_pc;
    logic        src2_imm;
    logic        use_mem;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        is_jalr;
    logic        wb;
    logic        muldiv;
    logic        sys;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready_a, out_valid_a, src1_a, src2_a, mem_a, memw_a, br_a, jmp_a, jalr_a;
  logic        wb_a, md_a, sys_a, ill_a;
  logic [31:0] out_pc_a, imm_a;
  logic [4:0]  rs1_a, rs2_a, rd_a, alu_a;
  logic [2:0]  f3_a;

  logic        in_ready_b, out_valid_b, src1_b, src2_b, mem_b, memw_b, br_b, jmp_b, jalr_b;
  logic        wb_b, md_b, sys_b, ill_b;
  logic [31:0] out_pc_b, imm_b;
  logic [4:0]  rs1_b, rs2_b, rd_b, alu_b;
  logic [2:0]  f3_b;

  dec_t bund_a, bund_b;
  assign bund_a = {rs1_a, rs2_a, rd_a, f3_a, imm_a, alu_a, src1_a, src2_a, mem_a, memw_a,
                   br_a, jmp_a, jalr_a, wb_a, md_a, sys_a, ill_a};
  assign bund_b = {rs1_b, rs2_b, rd_b, f3_b, imm_b, alu_b, src1_b, src2_b, mem_b, memw_b,
                   br_b, jmp_b, jalr_b, wb_b, md_b, sys_b, ill_b};

  entry_t q[$];
  int     checks = 0;
  int     errors = 0;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SYSTEM(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .rs1_addr(rs1_a), .rs2_addr(rs2_a), .rd_addr(rd_a), .func3(f3_a),
    .imm(imm_a), .alu_ctrl(alu_a), .alu_src1_is_pc(src1_a), .alu_src2_is_imm(src2_a),
    .use_mem(mem_a), .mem_write(memw_a), .is_branch(br_a), .is_jump(jmp_a),
    .is_jalr(jalr_a), .do_write_back(wb_a), .is_muldiv(md_a), .is_system(sys_a),
    .illegal(ill_a)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_SYSTEM(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .rs1_addr(rs1_b), .rs2_addr(rs2_b), .rd_addr(rd_b), .func3(f3_b),
    .imm(imm_b), .alu_ctrl(alu_b), .alu_src1_is_pc(src1_b), .alu_src2_is_imm(src2_b),
    .use_mem(mem_b), .mem_write(memw_b), .is_branch(br_b), .is_jump(jmp_b),
    .is_jalr(jalr_b), .do_write_back(wb_b), .is_muldiv(md_b), .is_system(sys_b),
    .illegal(ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference decode: derives every field from the instruction-format rules directly.
  function automatic dec_t modelDecode(input logic [31:0] ins, input bit en_m, input bit en_sys);
    dec_t       d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    byte        fmt;
    bit         ok;
    d   = '0;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    fmt = "N";
    ok  = 1'b1;
    case (op)
      7'b0110111: begin fmt = "U"; d.src2_imm = 1'b1; end
      7'b0010111: begin fmt = "U"; d.src1_pc = 1'b1; d.src2_imm = 1'b1; end
      7'b1101111: begin fmt = "J"; d.src1_pc = 1'b1; d.src2_imm = 1'b1; d.is_jump = 1'b1; end
      7'b1100111: begin
        fmt = "I"; d.src2_imm = 1'b1; d.is_jump = 1'b1; d.is_jalr = 1'b1; ok = (f3 == 0);
      end
      7'b1100011: begin
        fmt = "B"; d.is_branch = 1'b1; d.alu = {2'b10, f3}; ok = !(f3 inside {3'd2, 3'd3});
      end
      7'b0000011: begin
        fmt = "I"; d.src2_imm = 1'b1; d.use_mem = 1'b1; ok = !(f3 inside {3'd3, 3'd6, 3'd7});
      end
      7'b0100011: begin
        fmt = "S"; d.src2_imm = 1'b1; d.use_mem = 1'b1; d.mem_write = 1'b1; ok = (f3 <= 3'd2);
      end
      7'b0010011: begin
        fmt = "I"; d.src2_imm = 1'b1;
        d.alu = {1'b0, (f3 == 3'd5) && ins[30], f3};
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) ok = 1'b0;
      end
      7'b0110011: begin
        fmt = "R";
        if (f7 == 7'h00) d.alu = {2'b00, f3};
        else if (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) d.alu = {2'b01, f3};
        else if (f7 == 7'h01 && en_m) begin d.muldiv = 1'b1; d.alu = {2'b00, f3}; end
        else ok = 1'b0;
      end
      7'b0001111: fmt = "N";
      7'b1110011: begin
        fmt = "I"; d.sys = 1'b1;
        ok = en_sys && (ins == 32'h0000_0073 || ins == 32'h0010_0073);
      end
      default: ok = 1'b0;
    endcase
    if (fmt inside {"R", "I", "S", "B"}) begin d.rs1 = ins[19:15]; d.f3 = f3; end
    if (fmt inside {"R", "S", "B"}) d.rs2 = ins[24:20];
    if (fmt inside {"R", "I", "U", "J"}) d.rd = ins[11:7];
    case (fmt)
      "I": d.imm = {{20{ins[31]}}, ins[31:20]};
      "S": d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      "B": d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      "U": d.imm = {ins[31:12], 12'd0};
      "J": d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: d.imm = 32'd0;
    endcase
    d.wb = (fmt inside {"R", "I", "U", "J"}) && (d.rd != 5'd0);
    if (!ok) begin
      d.use_mem = 0; d.mem_write = 0; d.is_branch = 0; d.is_jump = 0; d.is_jalr = 0;
      d.wb = 0; d.muldiv = 0; d.sys = 0; d.alu = 5'd0; d.illegal = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] randomInstr();
    logic [6:0]  ops [0:10];
    logic [31:0] r;
    int          k;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) r[6:0] = ops[k];
    if (r[6:0] == 7'b0110011) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (r[6:0] == 7'b0010011 && $urandom_range(0, 1) == 1)
      r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (r[6:0] == 7'b1110011) begin
      case ($urandom_range(0, 2))
        0: r = 32'h0000_0073;
        1: r = 32'h0010_0073;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compareModel();
    checkOutput("in_ready_a", 128'(in_ready_a), 128'(q.size() < 2));
    checkOutput("in_ready_b", 128'(in_ready_b), 128'(q.size() < 2));
    checkOutput("out_valid_a", 128'(out_valid_a), 128'(q.size() > 0));
    checkOutput("out_valid_b", 128'(out_valid_b), 128'(q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("out_pc_a", 128'(out_pc_a), 128'(q[0].pc));
      checkOutput("out_pc_b", 128'(out_pc_b), 128'(q[0].pc));
      checkOutput("bundle_a", 128'(bund_a), 128'(modelDecode(q[0].instr, 1'b0, 1'b1)));
      checkOutput("bundle_b", 128'(bund_b), 128'(modelDecode(q[0].instr, 1'b1, 1'b0)));
    end
  endtask

  // Called at a falling edge: drive one cycle, advance the model, check after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    bit acc;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back('{instr: ins, pc: pc});
    end
    @(posedge clk);
    @(negedge clk);
    compareModel();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, 128'(out_valid_a), 128'(0));
    checkOutput({tag, "_in_ready"}, 128'(in_ready_a), 128'(1));
    checkOutput({tag, "_out_pc"}, 128'(out_pc_a), 128'(0));
    checkOutput({tag, "_bundle_a"}, 128'(bund_a), 128'(0));
    checkOutput({tag, "_bundle_b"}, 128'(bund_b), 128'(0));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    @(negedge clk);
    @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    // ADDI then SUB, then a write to x0
    applyStimulus(1, 32'h0050_0093, 32'h0, 1, 0);
    checkOutput("addi_rd", 128'(rd_a), 128'(5'd1));
    checkOutput("addi_imm", 128'(imm_a), 128'(32'd5));
    checkOutput("addi_alu", 128'(alu_a), 128'(5'b00000));
    checkOutput("addi_wb", 128'(wb_a), 128'(1));
    applyStimulus(1, 32'h4020_81B3, 32'h4, 1, 0);
    checkOutput("sub_alu", 128'(alu_a), 128'(5'b01000));
    checkOutput("sub_rs1", 128'(rs1_a), 128'(5'd1));
    checkOutput("sub_rs2", 128'(rs2_a), 128'(5'd2));
    checkOutput("sub_imm", 128'(imm_a), 128'(0));
    applyStimulus(1, 32'h0000_0013, 32'h8, 1, 0);
    checkOutput("nop_wb", 128'(wb_a), 128'(0));
    checkOutput("nop_rd", 128'(rd_a), 128'(0));
    checkOutput("nop_illegal", 128'(ill_a), 128'(0));
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Back-pressure: three offers while execute is stalled
    applyStimulus(1, 32'h0010_0093, 32'h0, 0, 0);
    checkOutput("bp_pc0", 128'(out_pc_a), 128'(32'h0));
    applyStimulus(1, 32'h0020_0113, 32'h4, 0, 0);
    checkOutput("bp_ready_low", 128'(in_ready_a), 128'(0));
    applyStimulus(1, 32'h0030_0193, 32'h8, 0, 0);
    checkOutput("bp_hold_pc0", 128'(out_pc_a), 128'(32'h0));
    applyStimulus(1, 32'h0030_0193, 32'h8, 1, 0);
    checkOutput("bp_pc4", 128'(out_pc_a), 128'(32'h4));
    checkOutput("bp_ready_back", 128'(in_ready_a), 128'(1));
    applyStimulus(1, 32'h0030_0193, 32'h8, 1, 0);
    checkOutput("bp_pc8", 128'(out_pc_a), 128'(32'h8));
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    checkOutput("bp_drained", 128'(out_valid_a), 128'(0));

    // Flush while both registers are occupied and a new word is offered
    applyStimulus(1, 32'h0010_0093, 32'h100, 0, 0);
    applyStimulus(1, 32'h0020_0113, 32'h104, 0, 0);
    applyStimulus(1, 32'h0030_0193, 32'h108, 0, 1);
    checkOutput("flush_valid", 128'(out_valid_a), 128'(0));
    checkOutput("flush_ready", 128'(in_ready_a), 128'(1));
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    checkOutput("flush_no_ghost", 128'(out_valid_a), 128'(0));

    // Illegal encodings, SYSTEM and M-extension across both parameter sets
    applyStimulus(1, 32'hFFFF_FFFF, 32'h200, 1, 0);
    checkOutput("ill_ones", 128'(ill_a), 128'(1));
    checkOutput("ill_ones_mem", 128'(mem_a), 128'(0));
    checkOutput("ill_ones_wb", 128'(wb_a), 128'(0));
    applyStimulus(1, 32'h0020_0073, 32'h204, 1, 0);
    checkOutput("ill_system", 128'(ill_a), 128'(1));
    applyStimulus(1, 32'h0000_0073, 32'h208, 1, 0);
    checkOutput("ecall_sys_a", 128'(sys_a), 128'(1));
    checkOutput("ecall_ill_b", 128'(ill_b), 128'(1));
    applyStimulus(1, 32'h0273_02B3, 32'h20C, 1, 0);
    checkOutput("mul_md_b", 128'(md_b), 128'(1));
    checkOutput("mul_rd_b", 128'(rd_b), 128'(5'd5));
    checkOutput("mul_ill_b", 128'(ill_b), 128'(0));
    checkOutput("mul_ill_a", 128'(ill_a), 128'(1));
    checkOutput("mul_md_a", 128'(md_a), 128'(0));
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Randomised traffic with stalls and occasional flushes
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), randomInstr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end

    // Reset mid-stream: outputs drop without waiting for a clock edge
    applyStimulus(1, 32'h0010_0093, 32'h300, 0, 0);
    applyStimulus(1, 32'h0020_0113, 32'h304, 0, 0);
    #2 rst = 1'b1;
    #1 checkResetState("midreset");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 32'h0050_0093, 32'h400, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
